// File: rtl/rgb_pwm_driver_if.sv
// Signal bundle between an RGB target source and the PWM driver.
// The master drives enable and targets; the slave (driver) returns PWM and status.
interface rgb_pwm_driver_if;
  logic       enable;
  logic [7:0] r_in;
  logic [7:0] g_in;
  logic [7:0] b_in;
  logic       r_pwm;
  logic       g_pwm;
  logic       b_pwm;
  logic       period_start;
  logic       settled;

  modport master (
    output enable, r_in, g_in, b_in,
    input  r_pwm, g_pwm, b_pwm, period_start, settled
  );

  modport slave (
    input  enable, r_in, g_in, b_in,
    output r_pwm, g_pwm, b_pwm, period_start, settled
  );
endinterface

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM LED driver with per-period rate-limited fading toward sampled targets.
// Targets are sampled at each period boundary; levels chase the previous targets by <= STEP.
module rgb_pwm_driver #(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned STEP     = 1
) (
  input logic              clk,
  input logic              rst,
  rgb_pwm_driver_if.slave  bus_io
);

  localparam logic [7:0] PreMax = 8'(PRESCALE - 1);
  localparam logic [7:0] StepW  = 8'(STEP);

  logic [7:0]      presc_q, presc_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [2:0][7:0] lvl_q, lvl_d;
  logic [2:0][7:0] tgt_q, tgt_d;
  logic [2:0]      pwm_q, pwm_d;
  logic            ps_q, ps_d;
  logic            settled_q, settled_d;
  logic [2:0][7:0] in_w;
  logic            en, tick, boundary;

  assign en   = bus_io.enable;
  assign in_w = {bus_io.b_in, bus_io.g_in, bus_io.r_in};

  // Move cur toward goal by at most StepW; cannot overshoot or wrap.
  function automatic logic [7:0] approach(input logic [7:0] cur, input logic [7:0] goal);
    logic [7:0] diff;
    approach = cur;
    diff     = 8'd0;
    if (cur < goal) begin
      diff     = goal - cur;
      approach = cur + ((diff > StepW) ? StepW : diff);
    end else if (cur > goal) begin
      diff     = cur - goal;
      approach = cur - ((diff > StepW) ? StepW : diff);
    end
  endfunction

  always_comb begin
    tick     = en && (presc_q == PreMax);
    boundary = tick && (cnt_q == 8'd254);

    presc_d = (!en || tick) ? 8'd0 : presc_q + 8'd1;
    if (!en || boundary) begin
      cnt_d = 8'd0;
    end else if (tick) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end

    lvl_d = lvl_q;
    tgt_d = tgt_q;
    pwm_d = '0;
    for (int c = 0; c < 3; c++) begin
      // Levels use the targets captured at the previous boundary.
      if (boundary) begin
        lvl_d[c] = approach(lvl_q[c], tgt_q[c]);
        tgt_d[c] = in_w[c];
      end
      // Compare against next-state counter so the sample aligns with period_start.
      pwm_d[c] = en && (cnt_d < lvl_d[c]);
    end

    ps_d      = boundary;
    settled_d = (lvl_d == tgt_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      cnt_q     <= '0;
      lvl_q     <= '0;
      tgt_q     <= '0;
      pwm_q     <= '0;
      ps_q      <= 1'b0;
      settled_q <= 1'b1;
    end else begin
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      lvl_q     <= lvl_d;
      tgt_q     <= tgt_d;
      pwm_q     <= pwm_d;
      ps_q      <= ps_d;
      settled_q <= settled_d;
    end
  end

  assign bus_io.r_pwm        = pwm_q[0];
  assign bus_io.g_pwm        = pwm_q[1];
  assign bus_io.b_pwm        = pwm_q[2];
  assign bus_io.period_start = ps_q;
  assign bus_io.settled      = settled_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Scoreboard bench for rgb_pwm_driver: three instances with different PRESCALE/STEP share stimulus;
// a period-level model queues expected levels per boundary, a monitor checks each full period.
module tb_rgb_pwm_driver;

  localparam int NDUT = 3;
  localparam int PRE [NDUT] = '{1, 1, 2};
  localparam int STP [NDUT] = '{255, 16, 64};

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } lv_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] r_in = 8'h00;
  logic [7:0] g_in = 8'h00;
  logic [7:0] b_in = 8'h00;

  always #5 clk = ~clk;

  rgb_pwm_driver_if if0 ();
  rgb_pwm_driver_if if1 ();
  rgb_pwm_driver_if if2 ();

  assign if0.enable = enable;
  assign if0.r_in   = r_in;
  assign if0.g_in   = g_in;
  assign if0.b_in   = b_in;
  assign if1.enable = enable;
  assign if1.r_in   = r_in;
  assign if1.g_in   = g_in;
  assign if1.b_in   = b_in;
  assign if2.enable = enable;
  assign if2.r_in   = r_in;
  assign if2.g_in   = g_in;
  assign if2.b_in   = b_in;

  logic [NDUT-1:0] r_o, g_o, b_o, ps_o, st_o;
  assign r_o  = {if2.r_pwm, if1.r_pwm, if0.r_pwm};
  assign g_o  = {if2.g_pwm, if1.g_pwm, if0.g_pwm};
  assign b_o  = {if2.b_pwm, if1.b_pwm, if0.b_pwm};
  assign ps_o = {if2.period_start, if1.period_start, if0.period_start};
  assign st_o = {if2.settled, if1.settled, if0.settled};

  rgb_pwm_driver #(.PRESCALE(1), .STEP(255)) dut0 (.clk(clk), .rst(rst), .bus_io(if0.slave));
  rgb_pwm_driver #(.PRESCALE(1), .STEP(16))  dut1 (.clk(clk), .rst(rst), .bus_io(if1.slave));
  rgb_pwm_driver #(.PRESCALE(2), .STEP(64))  dut2 (.clk(clk), .rst(rst), .bus_io(if2.slave));

  int checks   = 0;
  int failures = 0;

  task automatic check(input int k, input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", nm, k, $time, act, req);
    end
  endtask

  // Reference model: counts enabled clocks; every 255*PRESCALE of them is a boundary.
  int  lvl [NDUT][3];
  int  tgt [NDUT][3];
  int  cyc [NDUT];
  bit  m_settled [NDUT];
  bit  en_prev = 1'b0;
  lv_t sb_q [NDUT][$];

  function automatic int move(input int cur, input int goal, input int step);
    if (goal > cur) return cur + (((goal - cur) < step) ? (goal - cur) : step);
    if (goal < cur) return cur - (((cur - goal) < step) ? (cur - goal) : step);
    return cur;
  endfunction

  initial begin
    int ins [3];
    for (int k = 0; k < NDUT; k++) m_settled[k] = 1'b1;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        en_prev = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
          cyc[k] = 0;
          m_settled[k] = 1'b1;
          for (int c = 0; c < 3; c++) begin
            lvl[k][c] = 0;
            tgt[k][c] = 0;
          end
        end
      end else begin
        en_prev = enable;
        ins = '{int'(r_in), int'(g_in), int'(b_in)};
        for (int k = 0; k < NDUT; k++) begin
          if (!enable) begin
            cyc[k] = 0;
          end else begin
            cyc[k]++;
            if (cyc[k] == 255 * PRE[k]) begin
              cyc[k] = 0;
              for (int c = 0; c < 3; c++) begin
                lvl[k][c] = move(lvl[k][c], tgt[k][c], STP[k]);
                tgt[k][c] = ins[c];
              end
              m_settled[k] = (lvl[k][0] == tgt[k][0]) && (lvl[k][1] == tgt[k][1]) &&
                             (lvl[k][2] == tgt[k][2]);
              sb_q[k].push_back(lv_t'{8'(lvl[k][0]), 8'(lvl[k][1]), 8'(lvl[k][2])});
            end
          end
        end
      end
    end
  end

  // Monitor: pops one expectation per period_start, then totals high time across the period.
  initial begin
    int  hi [NDUT][3];
    int  ncyc [NDUT];
    bit  act [NDUT];
    lv_t cur [NDUT];
    for (int k = 0; k < NDUT; k++) act[k] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        check(k, "settled", int'(st_o[k]), int'(m_settled[k]));
        if (rst) begin
          act[k] = 1'b0;
          sb_q[k].delete();
          continue;
        end
        if (!en_prev) begin
          check(k, "disabled_outputs", int'({r_o[k], g_o[k], b_o[k], ps_o[k]}), 0);
          act[k] = 1'b0;
        end
        if (ps_o[k]) begin
          check(k, "ps_spacing", int'(act[k]), 0);
          check(k, "ps_expected", (sb_q[k].size() > 0) ? 1 : 0, 1);
          if (sb_q[k].size() > 0) begin
            cur[k]  = sb_q[k].pop_front();
            act[k]  = 1'b1;
            ncyc[k] = 0;
            for (int c = 0; c < 3; c++) hi[k][c] = 0;
          end
        end else begin
          check(k, "ps_missing", sb_q[k].size(), 0);
          sb_q[k].delete();
        end
        if (act[k]) begin
          hi[k][0] += int'(r_o[k]);
          hi[k][1] += int'(g_o[k]);
          hi[k][2] += int'(b_o[k]);
          ncyc[k]++;
          if (ncyc[k] == 255 * PRE[k]) begin
            check(k, "r_high_time", hi[k][0], int'(cur[k].r) * PRE[k]);
            check(k, "g_high_time", hi[k][1], int'(cur[k].g) * PRE[k]);
            check(k, "b_high_time", hi[k][2], int'(cur[k].b) * PRE[k]);
            act[k] = 1'b0;
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    for (int k = 0; k < NDUT; k++) begin
      check(k, "reset_outputs", int'({r_o[k], g_o[k], b_o[k], ps_o[k]}), 0);
      check(k, "reset_settled", int'(st_o[k]), 1);
    end
  endtask

  initial begin
    bit seen;
    cycles(3);
    check_reset_state();
    rst = 1'b0;
    cycles(2);

    // Fade up on r, extremes on g/b.
    r_in = 8'h81; g_in = 8'h00; b_in = 8'hFF; enable = 1'b1;
    cycles(255 * 20);
    // Instant/large jump, then fade down to 8 with a mid-period enable drop.
    r_in = 8'hC8;
    cycles(510 * 6);
    r_in = 8'h08;
    cycles(510 + 200);
    enable = 1'b0;
    cycles(300);
    enable = 1'b1;
    cycles(510 * 5);

    // Glitch on r_in entirely between two boundaries must be ignored.
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      seen = ps_o[0];
    end
    check(0, "ps_wait", int'(seen), 1);
    cycles(100);
    r_in = 8'h33;
    cycles(50);
    r_in = 8'h08;
    cycles(510 * 2);

    // Reset mid-fade.
    r_in = 8'hF0;
    cycles(255 * 3 + 77);
    rst = 1'b1;
    #1;
    check_reset_state();
    cycles(5);
    rst = 1'b0;
    cycles(255 * 4);

    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 9))
        0: enable = 1'b0;
        1: begin
          rst = 1'b1;
          cycles(3);
          rst = 1'b0;
        end
        default: begin
          enable = 1'b1;
          r_in = 8'($urandom_range(0, 255));
          g_in = 8'($urandom_range(0, 255));
          b_in = 8'($urandom_range(0, 255));
        end
      endcase
      cycles($urandom_range(50, 900));
    end
    enable = 1'b1;
    cycles(1100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
